// File: rtl/led_sw_pio_pkg.sv
// Shared register map and bus widths for the switch/LED peripheral.
package led_sw_pio_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_LED      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_LED_SET  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_LED_CLR  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_BLINK_EN = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_SEL = 3'd7;

endpackage

// File: rtl/sw_debounce.sv
// Per-bit switch conditioner: 2-flop synchroniser followed by a stability debouncer.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic q,
  output logic changed
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic             settled;

  // q flips at the next edge whenever this pulse is high; the top captures edges off it
  assign settled = (cnt == CNT_W'(DEBOUNCE_CYCLES));
  assign changed = (sync_q2 != q) && settled;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      q       <= 1'b0;
    end else begin
      sync_q1 <= d_async;
      sync_q2 <= sync_q1;
      if (sync_q2 == q) begin
        cnt <= '0;
      end else if (settled) begin
        q   <= sync_q2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_sw_pio.sv
// Avalon-MM switch/LED slave: debounced inputs, edge capture + irq, atomic LED ops, blink.
module led_sw_pio
  import led_sw_pio_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 4,
  parameter int unsigned LED_WIDTH       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned BLINK_DIV       = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [REG_W-1:0]     avs_writedata,
  output logic [REG_W-1:0]     avs_readdata,
  output logic                 irq,
  input  logic [SW_WIDTH-1:0]  sw_in,
  output logic [LED_WIDTH-1:0] led_out
);

  localparam int unsigned BLINK_CNT_W = $clog2(BLINK_DIV);

  logic [SW_WIDTH-1:0]    sw_db;
  logic [SW_WIDTH-1:0]    sw_chg;
  logic [SW_WIDTH-1:0]    irq_mask;
  logic [SW_WIDTH-1:0]    edge_sel;
  logic [SW_WIDTH-1:0]    edge_cap;
  logic [SW_WIDTH-1:0]    cap_set;
  logic [SW_WIDTH-1:0]    cap_clr;
  logic [LED_WIDTH-1:0]   led_reg;
  logic [LED_WIDTH-1:0]   blink_en;
  logic [LED_WIDTH-1:0]   led_nxt;
  logic [LED_WIDTH-1:0]   blink_nxt;
  logic [LED_WIDTH-1:0]   led_drv;
  logic [BLINK_CNT_W-1:0] blink_cnt;
  logic                   blink_wrap;
  logic                   phase;
  logic                   phase_nxt;
  logic [REG_W-1:0]       rd_mux;
  logic                   unused_wd;

  assign unused_wd = ^avs_writedata;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .d_async (sw_in[i]),
      .q       (sw_db[i]),
      .changed (sw_chg[i])
    );
  end

  // Next LED/blink state; led_out is driven from it so bus writes show after one edge
  always_comb begin
    led_nxt   = led_reg;
    blink_nxt = blink_en;
    if (avs_write) begin
      case (avs_address)
        ADDR_LED:      led_nxt   = avs_writedata[LED_WIDTH-1:0];
        ADDR_LED_SET:  led_nxt   = led_reg | avs_writedata[LED_WIDTH-1:0];
        ADDR_LED_CLR:  led_nxt   = led_reg & ~avs_writedata[LED_WIDTH-1:0];
        ADDR_BLINK_EN: blink_nxt = avs_writedata[LED_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign blink_wrap = (blink_cnt == BLINK_CNT_W'(BLINK_DIV - 1));
  assign phase_nxt  = phase ^ blink_wrap;
  assign led_drv    = led_nxt & ~(blink_nxt & {LED_WIDTH{~phase_nxt}});

  // A change pulse means q flips next edge, so the new level is ~sw_db
  assign cap_set = sw_chg & (~sw_db ^ edge_sel);
  assign cap_clr = (avs_write && (avs_address == ADDR_EDGE_CAP)) ?
                   avs_writedata[SW_WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA_IN:  rd_mux = REG_W'(sw_db);
      ADDR_LED:      rd_mux = REG_W'(led_reg);
      ADDR_BLINK_EN: rd_mux = REG_W'(blink_en);
      ADDR_IRQ_MASK: rd_mux = REG_W'(irq_mask);
      ADDR_EDGE_CAP: rd_mux = REG_W'(edge_cap);
      ADDR_EDGE_SEL: rd_mux = REG_W'(edge_sel);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg      <= '0;
      blink_en     <= '0;
      irq_mask     <= '0;
      edge_sel     <= '0;
      edge_cap     <= '0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
      led_out      <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      led_reg   <= led_nxt;
      blink_en  <= blink_nxt;
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_CNT_W'(1);
      phase     <= phase_nxt;
      led_out   <= led_drv;
      if (avs_write && (avs_address == ADDR_IRQ_MASK)) begin
        irq_mask <= avs_writedata[SW_WIDTH-1:0];
      end
      if (avs_write && (avs_address == ADDR_EDGE_SEL)) begin
        edge_sel <= avs_writedata[SW_WIDTH-1:0];
      end
      // New captures override a same-cycle clear
      edge_cap     <= (edge_cap & ~cap_clr) | cap_set;
      irq          <= |(edge_cap & irq_mask);
      avs_readdata <= avs_read ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_led_sw_pio.sv
// Directed and random checks of led_sw_pio against a cycle-level behavioural model.
module tb_led_sw_pio;

  localparam int unsigned SW_W  = 4;
  localparam int unsigned LED_W = 4;
  localparam int unsigned DB    = 8;
  localparam int unsigned BDIV  = 4;
  localparam logic [31:0] SMASK = 32'h0000_000F;
  localparam logic [31:0] LMASK = 32'h0000_000F;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       avs_address = '0;
  logic             avs_read = 1'b0;
  logic             avs_write = 1'b0;
  logic [31:0]      avs_writedata = '0;
  logic [31:0]      avs_readdata;
  logic             irq;
  logic [SW_W-1:0]  sw_in = '0;
  logic [LED_W-1:0] led_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_sw_pio #(
    .SW_WIDTH(SW_W), .LED_WIDTH(LED_W), .DEBOUNCE_CYCLES(DB), .BLINK_DIV(BDIV)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .sw_in         (sw_in),
    .led_out       (led_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: register map semantics, windowed debounce, cycle-count blink phase
  logic [31:0]     m_led, m_blink, m_mask, m_sel, m_cap, m_db, m_rdata, m_ledout;
  logic [31:0]     m_regs [8];
  logic [31:0]     m_new, m_clr;
  logic            m_irq, m_stable, m_phase;
  int              m_cyc;
  logic [SW_W-1:0] hist [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_led = '0; m_blink = '0; m_mask = '0; m_sel = '0; m_cap = '0; m_db = '0;
      m_rdata = '0; m_ledout = '0; m_irq = 1'b0; m_cyc = 0;
      hist.delete();
      for (int i = 0; i < DB + 3; i++) hist.push_back('0);
    end else begin
      m_regs[0] = m_db;    m_regs[1] = m_led;  m_regs[2] = '0;    m_regs[3] = '0;
      m_regs[4] = m_blink; m_regs[5] = m_mask; m_regs[6] = m_cap; m_regs[7] = m_sel;
      m_rdata = avs_read ? m_regs[avs_address] : '0;
      m_irq   = |(m_cap & m_mask);
      hist.push_back(sw_in);
      if (hist.size() > 32) void'(hist.pop_front());
      // A bit is accepted once DB+1 consecutive synchronised samples oppose it
      m_new = '0;
      for (int i = 0; i < SW_W; i++) begin
        m_stable = 1'b1;
        for (int j = 0; j <= DB; j++)
          if (hist[hist.size() - 3 - j][i] == m_db[i]) m_stable = 1'b0;
        if (m_stable) begin
          m_db[i] = ~m_db[i];
          if (m_db[i] != m_sel[i]) m_new[i] = 1'b1;
        end
      end
      m_clr = '0;
      if (avs_write) begin
        case (avs_address)
          3'd1: m_led   = avs_writedata & LMASK;
          3'd2: m_led   = m_led | (avs_writedata & LMASK);
          3'd3: m_led   = m_led & ~avs_writedata;
          3'd4: m_blink = avs_writedata & LMASK;
          3'd5: m_mask  = avs_writedata & SMASK;
          3'd6: m_clr   = avs_writedata & SMASK;
          3'd7: m_sel   = avs_writedata & SMASK;
          default: ;
        endcase
      end
      m_cap    = (m_cap & ~m_clr) | m_new;
      m_cyc++;
      m_phase  = ((m_cyc / BDIV) % 2) == 1;
      m_ledout = m_phase ? m_led : (m_led & ~m_blink);
    end
  end

  always @(negedge clk) begin
    check("led_out", 32'(led_out), m_ledout);
    check("irq", 32'(irq), 32'(m_irq));
    check("readdata", avs_readdata, m_rdata);
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    check(tag, avs_readdata, exp);
  endtask

  logic v, nv;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_led_out", 32'(led_out), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    for (int a = 0; a < 8; a++) rd_chk(3'(a), 32'h0, "reset_read");

    wr(3'd1, 32'h5); check("led_write", 32'(led_out), 32'h5);
    wr(3'd2, 32'h2); check("led_set", 32'(led_out), 32'h7);
    wr(3'd3, 32'h4); check("led_clr", 32'(led_out), 32'h3);
    rd_chk(3'd1, 32'h3, "led_readback");

    sw_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    sw_in[0] = 1'b0;
    repeat (20) @(negedge clk);
    rd_chk(3'd0, 32'h0, "bounce_data_in");
    rd_chk(3'd6, 32'h0, "bounce_edge_cap");

    wr(3'd5, 32'h1);
    wr(3'd7, 32'h0);
    sw_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    rd_chk(3'd0, 32'h0, "data_in_before_11");
    check("irq_at_11", 32'(irq), 32'h0);
    rd_chk(3'd0, 32'h1, "data_in_at_11");
    check("irq_at_12", 32'(irq), 32'h1);
    rd_chk(3'd6, 32'h1, "edge_cap_rise");
    wr(3'd6, 32'h1);
    check("irq_w1c_plus1", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_w1c_plus2", 32'(irq), 32'h0);

    wr(3'd7, 32'h4);
    sw_in[2] = 1'b1;
    repeat (15) @(negedge clk);
    rd_chk(3'd6, 32'h0, "no_rise_cap_sel1");
    sw_in[2] = 1'b0;
    repeat (10) @(negedge clk);
    wr(3'd6, 32'h4);
    rd_chk(3'd6, 32'h4, "capture_wins");
    wr(3'd6, 32'h4);

    wr(3'd1, 32'hF);
    wr(3'd4, 32'h1);
    for (int k = 0; k < 6; k++) begin
      v = led_out[0];
      nv = ~v;
      repeat (4) @(negedge clk);
      check("blink_toggle", 32'(led_out[0]), 32'(nv));
      check("blink_steady", 32'(led_out[3:1]), 32'h7);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_mid_led_out", 32'(led_out), 32'h0);
    check("reset_mid_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    rd_chk(3'd0, 32'h1, "post_reset_data_in");
    rd_chk(3'd6, 32'h1, "post_reset_edge_cap");
    check("post_reset_irq", 32'(irq), 32'h0);

    for (int k = 0; k < 2500; k++) begin
      avs_read      = ($urandom_range(0, 1) == 1);
      avs_write     = ($urandom_range(0, 3) == 0);
      avs_address   = 3'($urandom_range(0, 7));
      avs_writedata = $urandom;
      if ($urandom_range(0, 5) == 0) sw_in[$urandom_range(0, SW_W - 1)] ^= 1'b1;
      @(negedge clk);
    end
    avs_read = 1'b0;
    avs_write = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_sw_pio.md
# led_sw_pio

Parametrised Avalon-MM switch/LED peripheral for the HPS lightweight bridge. It replaces the fixed 4-bit switch input and 4-bit LED output PIO pair with one slave that adds:
- configurable widths
- per-bit switch synchronisation and debounce
- edge capture with a maskable interrupt
- atomic LED set/clear
- per-LED hardware blink

## Interface
- SW_WIDTH, 4, switch input count, 1..32
- LED_WIDTH, 4, LED output count, 1..32
- DEBOUNCE_CYCLES, 50000, cycles the input must be stable before it is accepted (1 ms at 50 MHz); 0 means synchroniser only
- BLINK_DIV, 25000000, cycles per blink phase half-period; ≥ 2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, valid one cycle after avs_read
- irq  out  1  level interrupt, active high
- sw_in  in  SW_WIDTH  raw asynchronous switch pins
- led_out  out  LED_WIDTH  LED drive

## Operation
Register map. Bits above the relevant width read 0, and writes to those bits are ignored.
- 0 DATA_IN (RO): debounced switch state.
- 1 LED (RW): LED register.
- 2 LED_SET (WO): LED |= writedata. Reads 0.
- 3 LED_CLR (WO): LED &= ~writedata. Reads 0.
- 4 BLINK_EN (RW): per-LED blink enable.
- 5 IRQ_MASK (RW): per-switch interrupt enable.
- 6 EDGE_CAP (R/W1C): latched edge events.
- 7 EDGE_SEL (RW): per switch, 0 captures rising edges, 1 captures falling edges.

Switch path:
- Each sw_in bit passes through a 2-flop synchroniser, then a debouncer.
- The debounced bit takes the synchronised value after that value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- Any return to equality clears the bit's counter.

Edge capture:
- A debounced transition in the selected direction sets EDGE_CAP[i].
- If a W1C of bit i and a new edge on bit i occur in the same cycle, the bit ends set (capture wins).

Interrupt:
- irq = registered |(EDGE_CAP & IRQ_MASK).

LED output:
- led_out[i] = BLINK_EN[i] ? (LED[i] & phase) : LED[i], registered.
- phase toggles every BLINK_DIV cycles from a free-running counter.

Bus behaviour:
- Write and read in the same cycle: the read returns the pre-write value.
- Unused or undefined addresses: reads return 0, writes are ignored.

## Timing
Reset values:
- All registers 0, including phase, counters and debounced state.
- avs_readdata = 0, irq = 0, led_out = 0.

Latencies:
- Read latency is 1 cycle and fixed; there is no waitrequest.
- A write to LED, LED_SET or LED_CLR changes led_out 1 cycle later.
- Switch path: sw_in change to DATA_IN is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Edge capture: EDGE_CAP sets in the same cycle the debounced bit changes. irq asserts 1 cycle after that.
- EDGE_CAP W1C: irq deasserts 2 cycles after the write cycle.

Boundary conditions:
- Switches held high through reset produce a rising debounced change after reset release. This sets EDGE_CAP; it does not raise irq while IRQ_MASK = 0.
- A bounce shorter than DEBOUNCE_CYCLES produces no DATA_IN change and no capture.
- Blink counter wraps at BLINK_DIV-1 to 0 and toggles phase on the wrap.
- Reset asserted mid-debounce or mid-blink clears all counters and phase immediately. No partial state survives reset.

## Structure
- Package led_sw_pio_pkg holds the eight register address constants (ADDR_DATA_IN … ADDR_EDGE_SEL) and REG_W = 32.
- Sub-module sw_debounce, one instance per switch bit via generate:
  - parameter DEBOUNCE_CYCLES
  - ports clk, reset, d_async, q, changed (1-cycle pulse)
  - contains the synchroniser, the counter of width $clog2(DEBOUNCE_CYCLES+1), and the output flop.
- The top level holds the register file, edge logic, blink divider and read mux.

## Test plan
Bench parameters: SW_WIDTH=4, LED_WIDTH=4, DEBOUNCE_CYCLES=8, BLINK_DIV=4.
- Reset state: reset released → led_out=0, irq=0; reads of addresses 0..7 all return 0.
- LED atomics:
  - write LED=0x5, then LED_SET=0x2, then LED_CLR=0x4 → led_out = 0x5, 0x7, 0x3, each 1 cycle after its write.
  - a read of addr 1 returns 0x3.
- Debounce:
  - sw_in[0] toggles high for 5 cycles, then low → DATA_IN stays 0.
  - sw_in[0] held high → DATA_IN=0x1 exactly 11 cycles after the change.
- Edge interrupt:
  - IRQ_MASK=0x1, EDGE_SEL=0, debounced rising edge on bit 0 → EDGE_CAP=0x1, irq high 1 cycle later.
  - write 0x1 to EDGE_CAP → irq low 2 cycles later.
- Capture wins over clear: falling edge on bit 2 with EDGE_SEL[2]=1, in the same cycle as a W1C of bit 2 → EDGE_CAP[2] reads 1.
- Blink and reset:
  - LED=0xF, BLINK_EN=0x1 → led_out[0] toggles every 4 cycles; bits 3:1 stay 1.
  - assert reset mid-period → led_out=0 immediately.
